// File: rtl/ble_cmd_link_if.sv
// Command/response handshake between the BLE serial link and the command processor.
// cmd_rdy rises with a new cmd and holds until a one-clk clr_cmd_rdy; send_resp is a one-clk request.
interface ble_cmd_link_if;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic        resp_busy;
   logic        frame_err;
   logic [1:0]  rx_state_dbg;
   logic        pair_state_dbg;
   logic        tx_state_dbg;

   modport master (
      input  cmd, cmd_rdy, resp_busy, frame_err, rx_state_dbg, pair_state_dbg, tx_state_dbg,
      output clr_cmd_rdy, send_resp
   );

   modport slave (
      output cmd, cmd_rdy, resp_busy, frame_err, rx_state_dbg, pair_state_dbg, tx_state_dbg,
      input  clr_cmd_rdy, send_resp
   );
endinterface

// File: rtl/ble_cmd_link.sv
// BLE UART front end: 8N1 receiver pairing bytes into 16-bit commands,
// plus a transmitter sending one acknowledge byte per send_resp request.
module ble_cmd_link #(
   parameter int         BAUD_DIV  = 434,
   parameter logic [7:0] RESP_BYTE = 8'hA5,
   parameter int         TO_CLKS   = 2500000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           RX,
   output logic           TX,
   ble_cmd_link_if.slave  link
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int TW = $clog2(TO_CLKS);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_CLKS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic       {WAIT_HI, WAIT_LO} pair_state_t;
   typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_t;

   rx_state_t   rx_state, rx_next;
   pair_state_t pair_state, pair_next;
   tx_state_t   tx_state, tx_next;

   logic          rx_s1, rx_s2, rx_s3;
   logic [BW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_fall, rx_tick, byte_vld, byte_err;

   logic [7:0]    hi_shadow;
   logic [TW-1:0] to_cnt;
   logic          load_hi, pair_done;

   logic [9:0]    tx_shift;
   logic [BW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic          pending, tx_load, bit_end, frame_end;

   assign rx_fall = rx_s3 & ~rx_s2;
   assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BAUD_LAST);

   always_comb begin
      rx_next  = rx_state;
      byte_vld = 1'b0;
      byte_err = 1'b0;
      case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: begin
            if (rx_tick) begin
               byte_vld = rx_s2;
               byte_err = ~rx_s2;
               rx_next  = RX_IDLE;
            end
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1    <= RX;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_state <= rx_next;
         rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + BW'(1);
         if (rx_state == RX_START) begin
            rx_bit <= '0;
         end else if (rx_state == RX_DATA && rx_tick) begin
            rx_bit   <= rx_bit + 3'd1;
            rx_shift <= {rx_s2, rx_shift[7:1]};
         end
      end
   end

   // A framing error or timeout while holding a high byte resynchronises to WAIT_HI.
   always_comb begin
      pair_next = pair_state;
      load_hi   = 1'b0;
      pair_done = 1'b0;
      case (pair_state)
         WAIT_HI: begin
            if (byte_vld) begin
               load_hi   = 1'b1;
               pair_next = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (byte_vld) begin
               pair_done = 1'b1;
               pair_next = WAIT_HI;
            end else if (byte_err || to_cnt == TO_LAST) begin
               pair_next = WAIT_HI;
            end
         end
         default: pair_next = WAIT_HI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_state     <= WAIT_HI;
         hi_shadow      <= '0;
         to_cnt         <= '0;
         link.cmd       <= '0;
         link.cmd_rdy   <= 1'b0;
         link.frame_err <= 1'b0;
      end else begin
         pair_state     <= pair_next;
         link.frame_err <= byte_err;
         if (load_hi) begin
            hi_shadow <= rx_shift;
            to_cnt    <= '0;
         end else if (pair_state == WAIT_LO) begin
            to_cnt <= to_cnt + TW'(1);
         end
         if (pair_done) link.cmd <= {hi_shadow, rx_shift};
         // A completing pair outranks a simultaneous clear.
         if (pair_done) link.cmd_rdy <= 1'b1;
         else if (link.clr_cmd_rdy) link.cmd_rdy <= 1'b0;
      end
   end

   assign bit_end   = (tx_cnt == BAUD_LAST);
   assign frame_end = bit_end && (tx_bit == 4'd9);

   always_comb begin
      tx_next = tx_state;
      tx_load = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (link.send_resp) begin
               tx_load = 1'b1;
               tx_next = TX_XMIT;
            end
         end
         TX_XMIT: begin
            if (frame_end) begin
               if (pending || link.send_resp) tx_load = 1'b1;
               else tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // The shifter fills with ones, so its LSB doubles as the idle-high line driver.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_shift <= '1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         pending  <= 1'b0;
      end else begin
         tx_state <= tx_next;
         if (tx_load) begin
            tx_shift <= {1'b1, RESP_BYTE, 1'b0};
            tx_cnt   <= '0;
            tx_bit   <= '0;
         end else if (tx_state == TX_XMIT) begin
            if (bit_end) begin
               tx_shift <= {1'b1, tx_shift[9:1]};
               tx_cnt   <= '0;
               tx_bit   <= tx_bit + 4'd1;
            end else begin
               tx_cnt <= tx_cnt + BW'(1);
            end
         end
         if (tx_state == TX_XMIT && frame_end) pending <= 1'b0;
         else if (tx_state == TX_XMIT && link.send_resp) pending <= 1'b1;
      end
   end

   assign TX                  = tx_shift[0];
   assign link.resp_busy      = (tx_state == TX_XMIT);
   assign link.rx_state_dbg   = rx_state;
   assign link.pair_state_dbg = pair_state;
   assign link.tx_state_dbg   = tx_state;
endmodule

// File: tb/tb_ble_cmd_link.sv
// Bench for ble_cmd_link: directed and randomized byte pairs on RX, response bursts
// decoded from TX, compared against a byte-level pairing model.
module tb_ble_cmd_link;
   localparam int         B    = 16;
   localparam int         HALF = B / 2;
   localparam int         TO   = 5000;
   localparam logic [7:0] RESP = 8'hA5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic RX    = 1'b1;
   logic TX;

   ble_cmd_link_if ifc ();

   ble_cmd_link #(.BAUD_DIV(B), .RESP_BYTE(RESP), .TO_CLKS(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .RX    (RX),
      .TX    (TX),
      .link  (ifc.slave)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          fe_total = 0;
   int          tx_n = 0;
   logic [7:0]  tx_byte [0:31];
   logic        tx_ok   [0:31];
   logic [15:0] exp_q[$];
   logic [15:0] exp_cmd = '0;
   logic        exp_rdy = 1'b0;
   logic        have_hi = 1'b0;
   logic [7:0]  hi_b = '0;

   always @(negedge clk) if (ifc.frame_err === 1'b1) fe_total++;

   // UART receiver model on TX: centre-samples each bit of every frame it sees.
   initial begin
      logic [7:0] d;
      logic       st, sp;
      forever begin
         @(negedge clk);
         if (TX === 1'b0) begin
            repeat (HALF) @(negedge clk);
            st = TX;
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge clk);
               d[i] = TX;
            end
            repeat (B) @(negedge clk);
            sp = TX;
            if (tx_n < 32) begin
               tx_byte[tx_n] = d;
               tx_ok[tx_n]   = (st === 1'b0) && (sp === 1'b1);
            end
            tx_n++;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame; clr_cmd_rdy is raised for the single clk numbered clr_at.
   task automatic uart_send(input logic [7:0] d, input logic stop_bit, input int clr_at);
      logic [9:0] fr;
      fr = {stop_bit, d, 1'b0};
      for (int i = 0; i < 10 * B; i++) begin
         @(negedge clk);
         RX = fr[i / B];
         ifc.clr_cmd_rdy = (i == clr_at);
      end
      @(negedge clk);
      RX = 1'b1;
      ifc.clr_cmd_rdy = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic ok);
      if (!ok) begin
         have_hi = 1'b0;
      end else if (!have_hi) begin
         hi_b    = b;
         have_hi = 1'b1;
      end else begin
         exp_q.push_back({hi_b, b});
         have_hi = 1'b0;
         exp_rdy = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ok);
      uart_send(d, ok, -1);
      model_byte(d, ok);
      idle(2);
   endtask

   task automatic check_cmd(input string tag);
      while (exp_q.size() > 0) exp_cmd = exp_q.pop_front();
      check({tag, ".cmd"}, 32'(ifc.cmd), 32'(exp_cmd));
      check({tag, ".rdy"}, 32'(ifc.cmd_rdy), 32'(exp_rdy));
   endtask

   task automatic pulse_clr();
      @(negedge clk) ifc.clr_cmd_rdy = 1'b1;
      @(negedge clk) ifc.clr_cmd_rdy = 1'b0;
      exp_rdy = 1'b0;
   endtask

   // np requests inside one frame: the first starts it, at most one more is queued.
   task automatic tx_burst(input string tag, input int np);
      int p1, p2, busy_len, n0, frames;
      p1       = $urandom_range(5, 70);
      p2       = $urandom_range(80, 150);
      frames   = (np >= 2) ? 2 : 1;
      busy_len = 0;
      n0       = tx_n;
      @(negedge clk) ifc.send_resp = 1'b1;
      for (int c = 1; c < 30 * B; c++) begin
         @(negedge clk);
         ifc.send_resp = (np > 1 && c == p1) || (np > 2 && c == p2);
         if (c == 1) check({tag, ".tx_start"}, 32'(TX), 32'd0);
         if (ifc.resp_busy === 1'b1) busy_len++;
         else break;
      end
      ifc.send_resp = 1'b0;
      idle(2);
      check({tag, ".busy_len"}, 32'(busy_len), 32'(frames * 10 * B));
      check({tag, ".frames"}, 32'(tx_n - n0), 32'(frames));
      for (int f = 0; f < frames; f++) begin
         if (n0 + f < 32) begin
            check({tag, ".byte"}, 32'(tx_byte[n0 + f]), 32'(RESP));
            check({tag, ".framing"}, 32'(tx_ok[n0 + f]), 32'd1);
         end
      end
      check({tag, ".tx_idle"}, 32'(TX), 32'd1);
   endtask

   initial begin
      int fe0;
      logic [7:0] hb, lb;
      logic bad;
      ifc.clr_cmd_rdy = 1'b0;
      ifc.send_resp   = 1'b0;

      #1 rst_n = 1'b0;
      idle(3);
      check("rst.cmd", 32'(ifc.cmd), 32'd0);
      check("rst.rdy", 32'(ifc.cmd_rdy), 32'd0);
      check("rst.tx", 32'(TX), 32'd1);
      check("rst.busy", 32'(ifc.resp_busy), 32'd0);
      check("rst.ferr", 32'(ifc.frame_err), 32'd0);
      check("rst.pair", 32'(ifc.pair_state_dbg), 32'd0);
      rst_n = 1'b1;
      idle(3);

      send_byte(8'h20, 1'b1);
      send_byte(8'h34, 1'b1);
      check_cmd("t1");
      pulse_clr();
      check_cmd("t1_clr");

      send_byte(8'h40, 1'b1);
      idle(TO + 50);
      have_hi = 1'b0;
      check("t2.pair_resync", 32'(ifc.pair_state_dbg), 32'd0);
      check_cmd("t2_timeout");
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check_cmd("t2");

      fe0 = fe_total;
      send_byte(8'h12, 1'b0);
      check("t3.ferr_pulse", 32'(fe_total - fe0), 32'd1);
      check("t3.pair", 32'(ifc.pair_state_dbg), 32'd0);
      send_byte(8'h31, 1'b1);
      send_byte(8'h05, 1'b1);
      check_cmd("t3");

      fe0 = fe_total;
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b0);
      check("t3b.ferr_pulse", 32'(fe_total - fe0), 32'd1);
      send_byte(8'h77, 1'b1);
      send_byte(8'h88, 1'b1);
      check_cmd("t3b");

      tx_burst("t4", 1);
      tx_burst("t5", 3);

      send_byte(8'h20, 1'b1);
      uart_send(8'h11, 1'b1, 2 + HALF + 9 * B);
      exp_rdy = 1'b0;
      model_byte(8'h11, 1'b1);
      idle(2);
      check_cmd("t6_set_wins");
      pulse_clr();
      @(negedge clk) RX = 1'b0;
      @(negedge clk);
      @(negedge clk) RX = 1'b1;
      idle(2 * B);
      check("t6.glitch_rx", 32'(ifc.rx_state_dbg), 32'd0);
      check("t6.glitch_pair", 32'(ifc.pair_state_dbg), 32'd0);
      send_byte(8'h77, 1'b1);
      send_byte(8'h88, 1'b1);
      check_cmd("t6_after_glitch");

      for (int r = 0; r < 8; r++) begin
         hb  = 8'($urandom);
         lb  = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         fork
            begin
               if ($urandom_range(0, 1) == 1) pulse_clr();
               send_byte(hb, 1'b1);
               idle($urandom_range(0, 20));
               send_byte(lb, !bad);
               check_cmd("rand");
            end
            begin
               if (r % 2 == 1) begin
                  idle($urandom_range(0, 100));
                  tx_burst("rand_tx", $urandom_range(1, 3));
               end
            end
         join
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
